wide_mult_result_checker: RTL and testbench



---
 rtl/wide_mult_result_checker_if.sv | 39 +++
 rtl/wide_mult_result_checker.sv | 210 +++++++++++++++++++++
 tb/tb_wide_mult_result_checker.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wide_mult_result_checker_if.sv
// Handshake bundle between the stimulus/response side and the result checker.
// The master drives run control, expected results and DUT results; the slave
// (the checker) returns status, statistics and FIFO occupancy.
interface wide_mult_result_checker_if #(
    parameter int RES_W = 256,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             start;
    logic [CNT_W-1:0] num_txn;
    logic             exp_valid;
    logic [RES_W-1:0] exp_data;
    logic             res_valid;
    logic [RES_W-1:0] res_data;

    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [CNT_W-1:0] first_bad_idx;
    logic             ovf_err;
    logic             unf_err;
    logic [LVL_W-1:0] fifo_level;

    modport master (
        output start, num_txn, exp_valid, exp_data, res_valid, res_data,
        input  busy, done, pass, match_cnt, mismatch_cnt, first_bad_idx,
               ovf_err, unf_err, fifo_level
    );

    modport slave (
        input  start, num_txn, exp_valid, exp_data, res_valid, res_data,
        output busy, done, pass, match_cnt, mismatch_cnt, first_bad_idx,
               ovf_err, unf_err, fifo_level
    );
endinterface

// File: rtl/wide_mult_result_checker.sv
// Response-side checker for the pipelined wide multiplier.
// Golden results are queued in an expected-result FIFO as transactions are
// issued; each DUT result pops the head, and the pair is compared one cycle
// later. Match/mismatch statistics, the first bad index and sticky FIFO
// errors are kept per run.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | accepting pushes and results until num_txn results have arrived
// CHECK | one cycle for the final registered compare to retire
// DONE  | run finished, statistics stable, pass valid; start re-arms
//
// DEPTH must be a power of two and at least 8 so a full pipeline (latency 7)
// of outstanding expected results always fits.
module wide_mult_result_checker #(
    parameter int RES_W = 256,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input logic                       clock,
    input logic                       resetn,
    wide_mult_result_checker_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] txn_target;
    logic [CNT_W-1:0] res_count;
    logic [CNT_W-1:0] match_q;
    logic [CNT_W-1:0] mismatch_q;
    logic [CNT_W-1:0] first_bad_q;
    logic             bad_seen;
    logic             ovf_q;
    logic             unf_q;

    logic [RES_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;

    logic             cmp_valid;
    logic             cmp_unf;
    logic [RES_W-1:0] cmp_exp;
    logic [RES_W-1:0] cmp_res;
    logic [CNT_W-1:0] cmp_idx;

    logic             in_run;
    logic             fifo_empty;
    logic             fifo_full;
    logic             res_acc;
    logic             pop_ok;
    logic             push_ok;
    logic             ovf_hit;
    logic             unf_hit;
    logic             start_ok;
    logic             cmp_bad;
    logic [CNT_W-1:0] res_count_nxt;
    logic             last_res;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign in_run        = (state == S_RUN);
    assign fifo_empty    = (level == '0);
    assign fifo_full     = (level == LVL_FULL);
    assign res_acc       = in_run && bus.res_valid;
    // No bypass: a push into an empty FIFO is not visible to a same-cycle pop.
    assign pop_ok        = res_acc && !fifo_empty;
    assign unf_hit       = res_acc && fifo_empty;
    // A full FIFO still accepts a push when the same cycle frees the head.
    assign push_ok       = in_run && bus.exp_valid && (!fifo_full || pop_ok);
    assign ovf_hit       = in_run && bus.exp_valid && fifo_full && !pop_ok;
    assign start_ok      = bus.start && ((state == S_IDLE) || (state == S_DONE));
    assign cmp_bad       = cmp_unf || (cmp_exp != cmp_res);
    assign res_count_nxt = res_count + 1'b1;
    assign last_res      = res_acc && (res_count_nxt == txn_target);

    // Expected-result storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.exp_data;
        end
    end

    // Run sequencing, FIFO pointers, compare stage and statistics.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            txn_target  <= '0;
            res_count   <= '0;
            match_q     <= '0;
            mismatch_q  <= '0;
            first_bad_q <= '1;
            bad_seen    <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            cmp_valid   <= 1'b0;
            cmp_unf     <= 1'b0;
            cmp_exp     <= '0;
            cmp_res     <= '0;
            cmp_idx     <= '0;
        end else begin
            cmp_valid <= res_acc;
            if (res_acc) begin
                cmp_unf <= fifo_empty;
                cmp_exp <= mem[rd_ptr];
                cmp_res <= bus.res_data;
                cmp_idx <= res_count;
            end

            if (cmp_valid) begin
                if (cmp_bad) begin
                    mismatch_q <= sat_inc(mismatch_q);
                    if (!bad_seen) begin
                        first_bad_q <= cmp_idx;
                        bad_seen    <= 1'b1;
                    end
                end else begin
                    match_q <= sat_inc(match_q);
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        txn_target  <= bus.num_txn;
                        res_count   <= '0;
                        match_q     <= '0;
                        mismatch_q  <= '0;
                        first_bad_q <= '1;
                        bad_seen    <= 1'b0;
                        ovf_q       <= 1'b0;
                        unf_q       <= 1'b0;
                        wr_ptr      <= '0;
                        rd_ptr      <= '0;
                        level       <= '0;
                        if (bus.num_txn == '0) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state  <= S_RUN;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (push_ok) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    if (pop_ok) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                    level <= level + LW'(push_ok) - LW'(pop_ok);
                    if (ovf_hit) begin
                        ovf_q <= 1'b1;
                    end
                    if (unf_hit) begin
                        unf_q <= 1'b1;
                    end
                    if (res_acc) begin
                        res_count <= res_count_nxt;
                    end
                    if (last_res) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    state  <= S_DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = done_q && (mismatch_q == '0) && !ovf_q && !unf_q && (level == '0);
    assign bus.match_cnt     = match_q;
    assign bus.mismatch_cnt  = mismatch_q;
    assign bus.first_bad_idx = first_bad_q;
    assign bus.ovf_err       = ovf_q;
    assign bus.unf_err       = unf_q;
    assign bus.fifo_level    = level;
endmodule

// File: tb/tb_wide_mult_result_checker.sv
// Directed bench for the wide multiply result checker: a table of complete
// runs with hand-computed statistics, plus short sequences for FIFO
// overflow/underflow, ignored strobes and an aborting reset.
module tb_wide_mult_result_checker;
    localparam int RES_W = 256;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int LAT   = 7;
    localparam int NONE  = 'hFFFF;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    wide_mult_result_checker_if #(.RES_W(RES_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    wide_mult_result_checker #(.RES_W(RES_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          num_txn;
        int          n_push;
        int          n_res;
        logic [63:0] base;
        logic [63:0] step;
        logic [63:0] hi;
        bit          geo;
        int          bad_idx;
        int          bad_bit;
        int          exp_match;
        int          exp_mismatch;
        int          exp_first_bad;
        bit          exp_pass;
        int          exp_level;
        int          exp_done_at;
    } vec_t;

    vec_t vecs [6];
    vec_t v47;

    function automatic vec_t mk(input int num_txn, input int n_push, input int n_res,
                                input logic [63:0] base, input logic [63:0] step,
                                input logic [63:0] hi, input bit geo,
                                input int bad_idx, input int bad_bit,
                                input int e_match, input int e_mis, input int e_fb,
                                input bit e_pass, input int e_level, input int e_done);
        vec_t v;
        v.num_txn = num_txn;  v.n_push = n_push;  v.n_res = n_res;
        v.base = base;  v.step = step;  v.hi = hi;  v.geo = geo;
        v.bad_idx = bad_idx;  v.bad_bit = bad_bit;
        v.exp_match = e_match;  v.exp_mismatch = e_mis;  v.exp_first_bad = e_fb;
        v.exp_pass = e_pass;  v.exp_level = e_level;  v.exp_done_at = e_done;
        return v;
    endfunction

    // Golden value i of a vector: arithmetic or x10 geometric low word, fixed top word.
    function automatic logic [RES_W-1:0] val(input vec_t v, input int i);
        logic [63:0] lo;
        lo = v.base;
        if (v.geo) begin
            for (int k = 0; k < i; k++) lo = lo * 64'd10;
        end else begin
            lo = v.base + v.step * 64'(i);
        end
        return {v.hi, 128'b0, lo};
    endfunction

    task automatic chk(input string nm, input logic [RES_W-1:0] act, input logic [RES_W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.num_txn   = '0;
        bus.exp_valid = 1'b0;
        bus.exp_data  = '0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle_inputs();
        resetn = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " busy"},          bus.busy,          0);
        chk({tag, " done"},          bus.done,          0);
        chk({tag, " pass"},          bus.pass,          0);
        chk({tag, " match_cnt"},     bus.match_cnt,     0);
        chk({tag, " mismatch_cnt"},  bus.mismatch_cnt,  0);
        chk({tag, " first_bad_idx"}, bus.first_bad_idx, NONE);
        chk({tag, " ovf_err"},       bus.ovf_err,       0);
        chk({tag, " unf_err"},       bus.unf_err,       0);
        chk({tag, " fifo_level"},    bus.fifo_level,    0);
    endtask

    // Pulse start at the negedge before edge P0; cycle c inputs are sampled at edge P(c+1).
    task automatic start_run(input int n);
        @(negedge clock);
        bus.start   = 1'b1;
        bus.num_txn = CNT_W'(n);
        @(negedge clock);
        bus.start   = 1'b0;
        bus.num_txn = '0;
    endtask

    task automatic drive_cycle(input vec_t v, input int c);
        logic [RES_W-1:0] rd;
        bus.exp_valid = (c < v.n_push);
        bus.exp_data  = (c < v.n_push) ? val(v, c) : '0;
        bus.res_valid = (c >= LAT) && (c - LAT < v.n_res);
        rd = '0;
        if (bus.res_valid) begin
            rd = val(v, c - LAT);
            if (c - LAT == v.bad_idx) rd[v.bad_bit] = ~rd[v.bad_bit];
        end
        bus.res_data = rd;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int done_at;
        int stim_end;
        done_at  = -1;
        stim_end = (v.n_push > LAT + v.n_res) ? v.n_push : LAT + v.n_res;
        start_run(v.num_txn);
        for (int c = 0; c < stim_end + 40; c++) begin
            if (bus.done && done_at < 0) done_at = c;
            if (done_at >= 0 && c >= stim_end) break;
            drive_cycle(v, c);
            @(negedge clock);
        end
        idle_inputs();
        chk({nm, " done_cycle"},    done_at,           v.exp_done_at);
        chk({nm, " match_cnt"},     bus.match_cnt,     v.exp_match);
        chk({nm, " mismatch_cnt"},  bus.mismatch_cnt,  v.exp_mismatch);
        chk({nm, " first_bad_idx"}, bus.first_bad_idx, v.exp_first_bad);
        chk({nm, " pass"},          bus.pass,          v.exp_pass);
        chk({nm, " fifo_level"},    bus.fifo_level,    v.exp_level);
        chk({nm, " busy"},          bus.busy,          0);
        chk({nm, " ovf_err"},       bus.ovf_err,       0);
        chk({nm, " unf_err"},       bus.unf_err,       0);
    endtask

    initial begin
        // num, push, res, base, step, hi, geo, bad_idx, bad_bit, match, mis, first_bad, pass, level, done_at
        vecs[0] = mk(4, 4, 4, 64'd2, 64'd1, 64'd0, 1'b0, -1, 0, 4, 0, NONE, 1'b1, 0, 12);
        vecs[1] = mk(3, 3, 3, 64'd10, 64'd0, 64'd0, 1'b1, 1, 0, 2, 1, 1, 1'b0, 0, 11);
        vecs[2] = mk(2, 3, 2, 64'h40, 64'h8, 64'd0, 1'b0, -1, 0, 2, 0, NONE, 1'b0, 1, 10);
        vecs[3] = mk(8, 8, 8, 64'h1234, 64'h1111, 64'hDEADBEEF_CAFEF00D, 1'b0, 7, 255,
                     7, 1, 7, 1'b0, 0, 16);
        vecs[4] = mk(0, 0, 0, 64'd0, 64'd0, 64'd0, 1'b0, -1, 0, 0, 0, NONE, 1'b1, 0, 0);
        vecs[5] = mk(12, 12, 12, 64'd5, 64'd7, 64'h0F0F, 1'b0, 0, 100, 11, 1, 0, 1'b0, 0, 20);
        v47     = mk(47, 47, 47, 64'h100, 64'd3, 64'h01234567_89ABCDEF, 1'b0, -1, 0,
                     47, 0, NONE, 1'b1, 0, 55);

        idle_inputs();
        do_reset();
        check_reset_vals("reset");

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Overflow: 17 pushes into a 16-deep FIFO with no results.
        do_reset();
        start_run(20);
        for (int c = 0; c < DEPTH; c++) begin
            bus.exp_valid = 1'b1;
            bus.exp_data  = RES_W'(c);
            @(negedge clock);
        end
        chk("ovf full level", bus.fifo_level, DEPTH);
        chk("ovf not yet",    bus.ovf_err,    0);
        bus.exp_data = RES_W'(DEPTH);
        @(negedge clock);
        idle_inputs();
        chk("ovf set",        bus.ovf_err,    1);
        chk("ovf level held", bus.fifo_level, DEPTH);

        // Same, but a result pops the head alongside the 17th push.
        do_reset();
        start_run(20);
        for (int c = 0; c < DEPTH; c++) begin
            bus.exp_valid = 1'b1;
            bus.exp_data  = RES_W'(c + 1);
            @(negedge clock);
        end
        bus.exp_data  = RES_W'(DEPTH + 1);
        bus.res_valid = 1'b1;
        bus.res_data  = RES_W'(1);
        @(negedge clock);
        idle_inputs();
        chk("full push+pop ovf",   bus.ovf_err,    0);
        chk("full push+pop level", bus.fifo_level, DEPTH);
        @(negedge clock);
        chk("full push+pop match", bus.match_cnt,  1);

        // Underflow: result arrives with the FIFO empty while a push lands.
        do_reset();
        start_run(5);
        bus.exp_valid = 1'b1;
        bus.exp_data  = RES_W'(32'h55);
        bus.res_valid = 1'b1;
        bus.res_data  = RES_W'(32'h55);
        @(negedge clock);
        idle_inputs();
        chk("unf set",     bus.unf_err,    1);
        chk("unf level",   bus.fifo_level, 1);
        @(negedge clock);
        chk("unf mismatch",  bus.mismatch_cnt,  1);
        chk("unf match",     bus.match_cnt,     0);
        chk("unf first_bad", bus.first_bad_idx, 0);

        // Strobes in IDLE are ignored.
        do_reset();
        bus.exp_valid = 1'b1;
        bus.exp_data  = RES_W'(7);
        bus.res_valid = 1'b1;
        bus.res_data  = RES_W'(9);
        @(negedge clock);
        @(negedge clock);
        idle_inputs();
        @(negedge clock);
        check_reset_vals("idle strobes");

        // Reset mid-run aborts to reset values; a fresh 47-vector run then passes.
        do_reset();
        start_run(47);
        for (int c = 0; c < 20; c++) begin
            drive_cycle(v47, c);
            @(negedge clock);
        end
        idle_inputs();
        resetn = 1'b0;
        #1;
        check_reset_vals("abort");
        @(negedge clock);
        resetn = 1'b1;
        run_vec(v47, "vec47");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
